// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//
// Single-issue, out-of-order issue queue between rename/dispatch and the
// functional-unit cluster.  Entries are kept in a collapsing, age-ordered
// array (slot 0 is the oldest).  Each cycle the oldest entry whose operands
// are available and whose target FU is ready is presented on fuinput_o.
// Because FU readiness is folded into select, a valid issue is always
// accepted and the entry leaves the queue at that edge.
//
// Optional build macro:
//   ISSUE_WAKE_BYPASS_EN - an entry whose last pending operand is woken in
//                          cycle N may issue in cycle N, with the bypassed
//                          write-back data on the operand field.
//
// Packed layouts:
//   fu_input_t  = {fu[FU_W], id[ROB_W], operand1[DATA_W], operand2[DATA_W]}
//   fu_output_t = {id[ROB_W], data[DATA_W]}; wake port k sits at bits
//                 [k*FUO_W +: FUO_W] of wake_i.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   flush_i                   empties the queue, drops same-cycle dispatch
//   disp_i / disp_valid_i     instruction to enqueue and its request
//   disp_rs{1,2}_pending_i    source operand not yet produced
//   disp_rs{1,2}_tag_i        producer ROB id for each source
//   disp_ready_o              queue can accept (from registered occupancy)
//   wake_i / wake_valid_i     write-back buses used as operand wakeup
//   fuinput_o / _o_valid      issued instruction and issue strobe
//   fuinput_ready_i           per-FU ready
//   occupancy_o               number of valid entries
// -----------------------------------------------------------------------------
module issue_queue #(
    parameter int NR_ENTRIES  = 8,
    parameter int NR_WB_PORTS = 2,
    parameter int NR_WAKE     = NR_WB_PORTS,
    parameter int NB_FU       = 4,
    parameter int DATA_W      = 32,
    parameter int ROB_W       = 4,
    localparam int FU_W       = (NB_FU > 1) ? $clog2(NB_FU) : 1,
    localparam int FUI_W      = FU_W + ROB_W + 2 * DATA_W,
    localparam int FUO_W      = ROB_W + DATA_W,
    localparam int OCC_W      = $clog2(NR_ENTRIES) + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic [FUI_W-1:0]         disp_i,
    input  logic                     disp_rs1_pending_i,
    input  logic                     disp_rs2_pending_i,
    input  logic [ROB_W-1:0]         disp_rs1_tag_i,
    input  logic [ROB_W-1:0]         disp_rs2_tag_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  logic [NR_WAKE*FUO_W-1:0] wake_i,
    input  logic [NR_WAKE-1:0]       wake_valid_i,
    output logic [FUI_W-1:0]         fuinput_o,
    output logic                     fuinput_o_valid,
    input  logic [NB_FU-1:0]         fuinput_ready_i,
    output logic [OCC_W-1:0]         occupancy_o
);

    localparam int IDX_W = $clog2(NR_ENTRIES);

    // Slots [0, occ) hold valid entries; nothing else marks validity.
    logic [FU_W-1:0]   e_fu  [NR_ENTRIES];
    logic [ROB_W-1:0]  e_id  [NR_ENTRIES];
    logic [DATA_W-1:0] e_op  [NR_ENTRIES][2];
    logic              e_pnd [NR_ENTRIES][2];
    logic [ROB_W-1:0]  e_tag [NR_ENTRIES][2];
    logic [OCC_W-1:0]  occ;

    logic [FU_W-1:0]   n_fu  [NR_ENTRIES];
    logic [ROB_W-1:0]  n_id  [NR_ENTRIES];
    logic [DATA_W-1:0] n_op  [NR_ENTRIES][2];
    logic              n_pnd [NR_ENTRIES][2];
    logic [ROB_W-1:0]  n_tag [NR_ENTRIES][2];

    logic [ROB_W-1:0]  wk_id   [NR_WAKE];
    logic [DATA_W-1:0] wk_data [NR_WAKE];
    logic              hit     [NR_ENTRIES][2];
    logic [DATA_W-1:0] hdat    [NR_ENTRIES][2];
    logic [ROB_W-1:0]  d_tag   [2];
    logic              d_pnd   [2];
    logic [DATA_W-1:0] d_op    [2];
    logic              d_hit   [2];
    logic [DATA_W-1:0] d_dat   [2];
    logic [DATA_W-1:0] op_eff  [NR_ENTRIES][2];

    logic              issue;
    logic [IDX_W-1:0]  sel;
    logic              accept;
    logic [OCC_W-1:0]  wr_slot;

    always_comb begin
        for (int k = 0; k < NR_WAKE; k++) begin
            {wk_id[k], wk_data[k]} = wake_i[k*FUO_W +: FUO_W];
        end
        d_tag[0] = disp_rs1_tag_i;
        d_tag[1] = disp_rs2_tag_i;
        d_pnd[0] = disp_rs1_pending_i;
        d_pnd[1] = disp_rs2_pending_i;
        d_op[0]  = disp_i[DATA_W +: DATA_W];
        d_op[1]  = disp_i[0 +: DATA_W];
    end

    // Tag match against every wake port.  Scanning from the highest port
    // down leaves the lowest matching port's data in place.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            d_hit[s] = 1'b0;
            d_dat[s] = '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                hit[i][s]  = 1'b0;
                hdat[i][s] = '0;
            end
            for (int k = NR_WAKE - 1; k >= 0; k--) begin
                if (wake_valid_i[k]) begin
                    if (wk_id[k] == d_tag[s]) begin
                        d_hit[s] = 1'b1;
                        d_dat[s] = wk_data[k];
                    end
                    for (int i = 0; i < NR_ENTRIES; i++) begin
                        if (wk_id[k] == e_tag[i][s]) begin
                            hit[i][s]  = 1'b1;
                            hdat[i][s] = wk_data[k];
                        end
                    end
                end
            end
        end
    end

    // Oldest-first select; FU readiness is part of the condition so the
    // chosen entry is guaranteed to be accepted.
    always_comb begin
        logic ops_rdy;
        issue = 1'b0;
        sel   = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            ops_rdy = 1'b1;
            for (int s = 0; s < 2; s++) begin
`ifdef ISSUE_WAKE_BYPASS_EN
                op_eff[i][s] = (e_pnd[i][s] && hit[i][s]) ? hdat[i][s] : e_op[i][s];
                ops_rdy      = ops_rdy && (!e_pnd[i][s] || hit[i][s]);
`else
                op_eff[i][s] = e_op[i][s];
                ops_rdy      = ops_rdy && !e_pnd[i][s];
`endif
            end
            if ((OCC_W'(i) < occ) && ops_rdy && fuinput_ready_i[e_fu[i]]) begin
                issue = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        if (!rstn || flush_i) begin
            issue = 1'b0;
        end
        fuinput_o_valid = issue;
        fuinput_o       = issue ? {e_fu[sel], e_id[sel], op_eff[sel][0], op_eff[sel][1]} : '0;
    end

    // Readiness looks only at registered occupancy: an issue in the same
    // cycle does not open a slot for dispatch.
    assign disp_ready_o = rstn && (occ < OCC_W'(NR_ENTRIES));
    assign accept       = disp_valid_i && disp_ready_o && !flush_i;
    assign wr_slot      = occ - OCC_W'(issue);
    assign occupancy_o  = occ;

    // Next entry state: collapse over the issued slot, apply wakeup, then
    // drop the dispatched instruction at the first free slot.
    always_comb begin
        int               src;
        logic [IDX_W-1:0] sidx;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            n_fu[i] = e_fu[i];
            n_id[i] = e_id[i];
            for (int s = 0; s < 2; s++) begin
                n_op[i][s]  = e_op[i][s];
                n_pnd[i][s] = e_pnd[i][s];
                n_tag[i][s] = e_tag[i][s];
            end
            src  = (issue && (IDX_W'(i) >= sel)) ? i + 1 : i;
            sidx = IDX_W'(src);
            if (src < NR_ENTRIES) begin
                n_fu[i] = e_fu[sidx];
                n_id[i] = e_id[sidx];
                for (int s = 0; s < 2; s++) begin
                    n_tag[i][s] = e_tag[sidx][s];
                    n_pnd[i][s] = e_pnd[sidx][s] && !hit[sidx][s];
                    n_op[i][s]  = (e_pnd[sidx][s] && hit[sidx][s]) ? hdat[sidx][s] : e_op[sidx][s];
                end
            end
            if (accept && (OCC_W'(i) == wr_slot)) begin
                n_fu[i] = disp_i[FUI_W-1 -: FU_W];
                n_id[i] = disp_i[2*DATA_W +: ROB_W];
                for (int s = 0; s < 2; s++) begin
                    n_tag[i][s] = d_tag[s];
                    n_pnd[i][s] = d_pnd[s] && !d_hit[s];
                    n_op[i][s]  = (d_pnd[s] && d_hit[s]) ? d_dat[s] : d_op[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush_i) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(accept) - OCC_W'(issue);
        end
    end

    // Entry payload carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        e_fu  <= n_fu;
        e_id  <= n_id;
        e_op  <= n_op;
        e_pnd <= n_pnd;
        e_tag <= n_tag;
    end

endmodule

// File: tb/tb_issue_queue.sv
`timescale 1ns/1ps
module tb_issue_queue;

    localparam int NR    = 8;
    localparam int NW    = 2;
    localparam int NFU   = 4;
    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int FUI_W = 2 + RW + 2 * DW;
    localparam logic [1:0] ALU = 2'd0, LSU = 2'd1, MUL = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn, flush, d_vld, d_p1, d_p2;
    logic [1:0]       d_fu;
    logic [RW-1:0]    d_id, d_t1, d_t2;
    logic [DW-1:0]    d_op1, d_op2;
    logic [RW-1:0]    wid  [NW];
    logic [DW-1:0]    wdat [NW];
    logic [NW-1:0]    wvld;
    logic [NFU-1:0]   fu_rdy;
    logic [FUI_W-1:0] disp_w;
    logic [NW*(RW+DW)-1:0] wake_w;
    logic             disp_ready, iss_vld;
    logic [FUI_W-1:0] iss;
    logic [3:0]       occ;

    assign disp_w = {d_fu, d_id, d_op1, d_op2};
    assign wake_w = {wid[1], wdat[1], wid[0], wdat[0]};

    issue_queue #(.NR_ENTRIES(NR), .NR_WB_PORTS(NW), .NR_WAKE(NW), .NB_FU(NFU),
                  .DATA_W(DW), .ROB_W(RW)) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush), .disp_i(disp_w),
        .disp_rs1_pending_i(d_p1), .disp_rs2_pending_i(d_p2),
        .disp_rs1_tag_i(d_t1), .disp_rs2_tag_i(d_t2),
        .disp_valid_i(d_vld), .disp_ready_o(disp_ready),
        .wake_i(wake_w), .wake_valid_i(wvld),
        .fuinput_o(iss), .fuinput_o_valid(iss_vld),
        .fuinput_ready_i(fu_rdy), .occupancy_o(occ)
    );

    // Reference model: a plain age-ordered list of waiting instructions.
    typedef struct packed {
        logic [1:0] fu; logic [RW-1:0] id; logic [DW-1:0] op1, op2;
        logic p1, p2; logic [RW-1:0] t1, t2;
    } ent_t;
    ent_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [FUI_W-1:0] word(input logic [1:0] fu, input logic [RW-1:0] id,
                                              input logic [DW-1:0] o1, input logic [DW-1:0] o2);
        return {fu, id, o1, o2};
    endfunction

    function automatic void wlook(input logic [RW-1:0] tag, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        for (int k = 0; k < NW; k++)
            if (!h && wvld[k] && wid[k] == tag) begin h = 1'b1; d = wdat[k]; end
    endfunction

    function automatic logic ops_ready(input ent_t e);
        logic r1, r2;
`ifdef ISSUE_WAKE_BYPASS_EN
        logic h; logic [DW-1:0] d;
`endif
        r1 = !e.p1;
        r2 = !e.p2;
`ifdef ISSUE_WAKE_BYPASS_EN
        if (e.p1) begin wlook(e.t1, h, d); r1 = h; end
        if (e.p2) begin wlook(e.t2, h, d); r2 = h; end
`endif
        return r1 && r2;
    endfunction

    function automatic logic [FUI_W-1:0] issue_word(input ent_t e);
        logic [DW-1:0] o1, o2;
`ifdef ISSUE_WAKE_BYPASS_EN
        logic h; logic [DW-1:0] d;
`endif
        o1 = e.op1;
        o2 = e.op2;
`ifdef ISSUE_WAKE_BYPASS_EN
        if (e.p1) begin wlook(e.t1, h, d); if (h) o1 = d; end
        if (e.p2) begin wlook(e.t2, h, d); if (h) o2 = d; end
`endif
        return {e.fu, e.id, o1, o2};
    endfunction

    function automatic int model_sel();
        if (!rstn || flush) return -1;
        for (int i = 0; i < q.size(); i++)
            if (ops_ready(q[i]) && fu_rdy[q[i].fu]) return i;
        return -1;
    endfunction

    // Advance the model with the inputs currently driven, then the clock.
    task automatic tick();
        int idx; logic acc, h; logic [DW-1:0] d; ent_t e;
        idx = model_sel();
        acc = d_vld && rstn && !flush && (q.size() < NR);
        e.fu = d_fu; e.id = d_id; e.op1 = d_op1; e.op2 = d_op2;
        e.p1 = d_p1; e.p2 = d_p2; e.t1 = d_t1; e.t2 = d_t2;
        if (e.p1) begin wlook(e.t1, h, d); if (h) begin e.p1 = 1'b0; e.op1 = d; end end
        if (e.p2) begin wlook(e.t2, h, d); if (h) begin e.p2 = 1'b0; e.op2 = d; end end
        if (!rstn || flush) begin
            q.delete();
        end else begin
            if (idx >= 0) q.delete(idx);
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].p1) begin wlook(q[i].t1, h, d); if (h) begin q[i].p1 = 1'b0; q[i].op1 = d; end end
                if (q[i].p2) begin wlook(q[i].t2, h, d); if (h) begin q[i].p2 = 1'b0; q[i].op2 = d; end end
            end
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; d_vld = 1'b0; wvld = '0;
    endtask

    task automatic set_disp(input logic [1:0] fu, input logic [RW-1:0] id, input logic [DW-1:0] o1,
                            input logic [DW-1:0] o2, input logic p1, input logic [RW-1:0] t1,
                            input logic p2, input logic [RW-1:0] t2);
        d_vld = 1'b1; d_fu = fu; d_id = id; d_op1 = o1; d_op2 = o2;
        d_p1 = p1; d_t1 = t1; d_p2 = p2; d_t2 = t2;
    endtask

    task automatic test_reset();
        rstn = 1'b0; idle(); fu_rdy = 4'hF;
        for (int k = 0; k < NW; k++) begin wid[k] = '0; wdat[k] = '0; end
        set_disp(ALU, 4'd3, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({iss_vld, iss} !== '0) begin n_bad++; $display("FAIL reset_issue: got %b/%h want 0/0", iss_vld, iss); end
            n_cmp++; if (disp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", disp_ready); end
            n_cmp++; if (occ !== 4'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occ); end
            tick();
        end
        rstn = 1'b1; idle();
        @(negedge clk);
        n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", disp_ready); end
        n_cmp++; if ({iss_vld, occ} !== 5'd0) begin n_bad++; $display("FAIL release_idle: got vld %b occ %0d want 0/0", iss_vld, occ); end
        tick();
    endtask

    task automatic test_ready_dispatch();
        set_disp(ALU, 4'd5, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL rdy_same_cycle: got %b want 0", iss_vld); end
        tick(); idle();
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== {1'b1, word(ALU, 4'd5, 32'h11, 32'h22)}) begin n_bad++; $display("FAIL rdy_issue: got %b/%h want 1/%h", iss_vld, iss, word(ALU, 4'd5, 32'h11, 32'h22)); end
        n_cmp++; if (occ !== 4'd1) begin n_bad++; $display("FAIL rdy_occ1: got %0d want 1", occ); end
        tick();
        @(negedge clk);
        n_cmp++; if ({iss_vld, occ} !== 5'd0) begin n_bad++; $display("FAIL rdy_drained: got vld %b occ %0d want 0/0", iss_vld, occ); end
    endtask

    task automatic test_dispatch_capture();
        set_disp(MUL, 4'd6, 32'h33, 32'hBAD, 1'b0, 4'd0, 1'b1, 4'd9);
        wvld = 2'b11; wid[0] = 4'd3; wdat[0] = 32'h1234; wid[1] = 4'd9; wdat[1] = 32'h99;
        tick(); idle();
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== {1'b1, word(MUL, 4'd6, 32'h33, 32'h99)}) begin n_bad++; $display("FAIL capture_issue: got %b/%h want 1/%h", iss_vld, iss, word(MUL, 4'd6, 32'h33, 32'h99)); end
        tick();
    endtask

    task automatic test_ooo_wakeup();
        logic [FUI_W:0] exp;
        set_disp(ALU, 4'd1, 32'h0, 32'h22, 1'b1, 4'd7, 1'b0, 4'd0);
        tick();
        set_disp(ALU, 4'd2, 32'h44, 32'h55, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL ooo_pending_holds: got %b want 0", iss_vld); end
        tick(); idle();
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== {1'b1, word(ALU, 4'd2, 32'h44, 32'h55)}) begin n_bad++; $display("FAIL ooo_young_first: got %b/%h want 1/%h", iss_vld, iss, word(ALU, 4'd2, 32'h44, 32'h55)); end
        tick();
        // Both ports carry tag 7; port 0 must win.
        wvld = 2'b11; wid[0] = 4'd7; wdat[0] = 32'hDEAD; wid[1] = 4'd7; wdat[1] = 32'hBEEF;
`ifdef ISSUE_WAKE_BYPASS_EN
        exp = {1'b1, word(ALU, 4'd1, 32'hDEAD, 32'h22)};
`else
        exp = '0;
`endif
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== exp) begin n_bad++; $display("FAIL ooo_wake_cycle: got %b/%h want %h", iss_vld, iss, exp); end
        tick(); idle();
`ifdef ISSUE_WAKE_BYPASS_EN
        exp = '0;
`else
        exp = {1'b1, word(ALU, 4'd1, 32'hDEAD, 32'h22)};
`endif
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== exp) begin n_bad++; $display("FAIL ooo_wake_next: got %b/%h want %h", iss_vld, iss, exp); end
        tick();
    endtask

    task automatic test_fu_not_ready();
        fu_rdy = 4'b1101;
        set_disp(LSU, 4'd3, 32'hA0, 32'hA1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        set_disp(ALU, 4'd4, 32'hB0, 32'hB1, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        n_cmp++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL fu_lsu_blocked: got %b want 0", iss_vld); end
        tick(); idle();
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== {1'b1, word(ALU, 4'd4, 32'hB0, 32'hB1)}) begin n_bad++; $display("FAIL fu_alu_passes: got %b/%h want 1/%h", iss_vld, iss, word(ALU, 4'd4, 32'hB0, 32'hB1)); end
        tick();
        @(negedge clk);
        n_cmp++; if ({iss_vld, occ} !== {1'b0, 4'd1}) begin n_bad++; $display("FAIL fu_lsu_waits: got vld %b occ %0d want 0/1", iss_vld, occ); end
        tick();
        fu_rdy = 4'hF;
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== {1'b1, word(LSU, 4'd3, 32'hA0, 32'hA1)}) begin n_bad++; $display("FAIL fu_lsu_goes: got %b/%h want 1/%h", iss_vld, iss, word(LSU, 4'd3, 32'hA0, 32'hA1)); end
        tick();
    endtask

    task automatic test_full();
        fu_rdy = 4'b1110;
        for (int j = 0; j < NR; j++) begin
            set_disp(ALU, 4'(8 + j), 32'(j), 32'(3 * j), 1'b0, 4'd0, 1'b0, 4'd0);
            tick();
        end
        fu_rdy = 4'hF;
        set_disp(ALU, 4'd0, 32'hF00, 32'hF01, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        n_cmp++; if ({disp_ready, occ} !== {1'b0, 4'd8}) begin n_bad++; $display("FAIL full_ready_low: got rdy %b occ %0d want 0/8", disp_ready, occ); end
        n_cmp++; if ({iss_vld, iss} !== {1'b1, word(ALU, 4'd8, 32'd0, 32'd0)}) begin n_bad++; $display("FAIL full_issue0: got %b/%h want 1/%h", iss_vld, iss, word(ALU, 4'd8, 32'd0, 32'd0)); end
        tick(); idle();
        @(negedge clk);
        n_cmp++; if ({disp_ready, occ} !== {1'b1, 4'd7}) begin n_bad++; $display("FAIL full_ready_back: got rdy %b occ %0d want 1/7", disp_ready, occ); end
        for (int j = 1; j < NR; j++) begin
            if (j > 1) @(negedge clk);
            n_cmp++; if ({iss_vld, iss} !== {1'b1, word(ALU, 4'(8 + j), 32'(j), 32'(3 * j))}) begin n_bad++; $display("FAIL full_drain_%0d: got %b/%h want 1/%h", j, iss_vld, iss, word(ALU, 4'(8 + j), 32'(j), 32'(3 * j))); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if ({iss_vld, occ} !== 5'd0) begin n_bad++; $display("FAIL full_dropped: got vld %b occ %0d want 0/0", iss_vld, occ); end
    endtask

    task automatic test_flush();
        fu_rdy = 4'b1110;
        for (int j = 0; j < 4; j++) begin
            set_disp(ALU, 4'(1 + j), 32'(j), 32'(j), 1'b0, 4'd0, 1'b0, 4'd0);
            tick();
        end
        set_disp(ALU, 4'd6, 32'h66, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0);
        flush = 1'b1; fu_rdy = 4'hF;
        @(negedge clk);
        n_cmp++; if ({iss_vld, iss} !== '0) begin n_bad++; $display("FAIL flush_no_issue: got %b/%h want 0/0", iss_vld, iss); end
        n_cmp++; if (occ !== 4'd4) begin n_bad++; $display("FAIL flush_occ_before: got %0d want 4", occ); end
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({iss_vld, occ} !== 5'd0) begin n_bad++; $display("FAIL flush_empty_%0d: got vld %b occ %0d want 0/0", c, iss_vld, occ); end
            tick();
        end
    endtask

    task automatic test_random();
        int s;
        logic [FUI_W:0] exp;
        for (int c = 0; c < 800; c++) begin
            rstn  = ($urandom_range(0, 79) != 0);
            flush = ($urandom_range(0, 39) == 0);
            d_vld = ($urandom_range(0, 9) < 6);
            d_fu  = 2'($urandom_range(0, 3));
            d_id  = 4'($urandom);
            d_op1 = $urandom; d_op2 = $urandom;
            d_p1  = ($urandom_range(0, 2) == 0); d_t1 = 4'($urandom_range(0, 3));
            d_p2  = ($urandom_range(0, 2) == 0); d_t2 = 4'($urandom_range(0, 3));
            for (int k = 0; k < NW; k++) begin
                wvld[k] = ($urandom_range(0, 2) == 0);
                wid[k]  = 4'($urandom_range(0, 3));
                wdat[k] = $urandom;
            end
            fu_rdy = 4'($urandom) | 4'($urandom);
            @(negedge clk);
            s = model_sel();
            exp = '0;
            if (s >= 0) exp = {1'b1, issue_word(q[s])};
            n_cmp++; if ({iss_vld, iss} !== exp) begin n_bad++; $display("FAIL rand_issue c%0d: got %b/%h want %h", c, iss_vld, iss, exp); end
            n_cmp++; if (disp_ready !== (rstn && q.size() < NR)) begin n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, disp_ready, rstn && q.size() < NR); end
            n_cmp++; if (occ !== 4'(q.size())) begin n_bad++; $display("FAIL rand_occ c%0d: got %0d want %0d", c, occ, q.size()); end
            tick();
        end
        rstn = 1'b1; idle();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_dispatch_capture();
        test_ooo_wakeup();
        test_fu_not_ready();
        test_full();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
